// File: rtl/calc1_pkg.sv
// Shared constants and types for the calc1 request arbiter and its ALU.
// Command/response encodings, port-state encoding and the round-robin index helper.
package calc1_pkg;

  localparam int CALC1_NUM_PORTS = 4;
  localparam int CALC1_DATA_W    = 32;
  localparam int CALC1_CMD_W     = 4;
  localparam int CALC1_RESP_W    = 2;

  typedef enum logic [CALC1_CMD_W-1:0] {
    CMD_NONE = 4'd0,
    CMD_ADD  = 4'd1,
    CMD_SUB  = 4'd2,
    CMD_SHL  = 4'd5,
    CMD_SHR  = 4'd6
  } cmd_e;

  typedef enum logic [CALC1_RESP_W-1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_ERR  = 2'd2
  } resp_e;

  // Per-port request life cycle: operand-1 capture -> operand-2 capture -> waiting for the ALU.
  typedef enum logic [1:0] {
    PORT_IDLE    = 2'd0,
    PORT_OP2     = 2'd1,
    PORT_PENDING = 2'd2
  } port_state_e;

  function automatic logic [1:0] next_port(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/calc1_req_arbiter_if.sv
// Requester-side bus of calc1_req_arbiter: four command/operand inputs and four response outputs.
// The arbiter connects through the slave modport; a requester model uses master.
interface calc1_req_arbiter_if
  import calc1_pkg::*;
#(
  parameter int DATA_W = CALC1_DATA_W
);

  logic [CALC1_CMD_W-1:0]  req1_cmd_in;
  logic [CALC1_CMD_W-1:0]  req2_cmd_in;
  logic [CALC1_CMD_W-1:0]  req3_cmd_in;
  logic [CALC1_CMD_W-1:0]  req4_cmd_in;
  logic [DATA_W-1:0]       req1_data_in;
  logic [DATA_W-1:0]       req2_data_in;
  logic [DATA_W-1:0]       req3_data_in;
  logic [DATA_W-1:0]       req4_data_in;
  logic [CALC1_RESP_W-1:0] out_resp1;
  logic [CALC1_RESP_W-1:0] out_resp2;
  logic [CALC1_RESP_W-1:0] out_resp3;
  logic [CALC1_RESP_W-1:0] out_resp4;
  logic [DATA_W-1:0]       out_data1;
  logic [DATA_W-1:0]       out_data2;
  logic [DATA_W-1:0]       out_data3;
  logic [DATA_W-1:0]       out_data4;

  modport master (
    output req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
    output req1_data_in, req2_data_in, req3_data_in, req4_data_in,
    input  out_resp1, out_resp2, out_resp3, out_resp4,
    input  out_data1, out_data2, out_data3, out_data4
  );

  modport slave (
    input  req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
    input  req1_data_in, req2_data_in, req3_data_in, req4_data_in,
    output out_resp1, out_resp2, out_resp3, out_resp4,
    output out_data1, out_data2, out_data3, out_data4
  );

endinterface

// File: rtl/calc1_alu.sv
// Shared combinational ALU: add / subtract / shift with overflow, underflow and invalid-command errors.
// Result data is forced to zero whenever the response is not a success.
module calc1_alu
  import calc1_pkg::*;
#(
  parameter int DATA_W = CALC1_DATA_W
) (
  input  logic [CALC1_CMD_W-1:0]  cmd,
  input  logic [DATA_W-1:0]       op1,
  input  logic [DATA_W-1:0]       op2,
  output logic [CALC1_RESP_W-1:0] resp,
  output logic [DATA_W-1:0]       result
);

  localparam int SHAMT_W = $clog2(DATA_W);

  logic [DATA_W:0] sum;

  assign sum = {1'b0, op1} + {1'b0, op2};

  always_comb begin
    resp   = RESP_ERR;
    result = '0;
    case (cmd)
      CMD_ADD: begin
        if (!sum[DATA_W]) begin
          resp   = RESP_OK;
          result = sum[DATA_W-1:0];
        end
      end
      CMD_SUB: begin
        if (op2 <= op1) begin
          resp   = RESP_OK;
          result = op1 - op2;
        end
      end
      CMD_SHL: begin
        resp   = RESP_OK;
        result = op1 << op2[SHAMT_W-1:0];
      end
      CMD_SHR: begin
        resp   = RESP_OK;
        result = op1 >> op2[SHAMT_W-1:0];
      end
      default: begin
        resp   = RESP_ERR;
        result = '0;
      end
    endcase
  end

endmodule

// File: rtl/calc1_req_arbiter.sv
// Four-port request arbiter in front of one shared calc1_alu, with registered one-cycle responses.
// Define CALC1_ARB_FIXED_PRIO_EN for fixed priority (port 1 highest); default is round-robin.
module calc1_req_arbiter
  import calc1_pkg::*;
#(
  parameter int NUM_PORTS = CALC1_NUM_PORTS,
  parameter int DATA_W    = CALC1_DATA_W
) (
  input logic                c_clk,
  input logic                reset,
  calc1_req_arbiter_if.slave bus
);

  localparam int PORT_IDX_W = $clog2(NUM_PORTS);

  logic [CALC1_CMD_W-1:0]  cmd_in   [NUM_PORTS];
  logic [DATA_W-1:0]       data_in  [NUM_PORTS];
  logic [CALC1_CMD_W-1:0]  cmd_q    [NUM_PORTS];
  logic [DATA_W-1:0]       op1_q    [NUM_PORTS];
  logic [DATA_W-1:0]       op2_q    [NUM_PORTS];
  logic [CALC1_RESP_W-1:0] resp_q   [NUM_PORTS];
  logic [DATA_W-1:0]       data_q   [NUM_PORTS];

  logic [NUM_PORTS-1:0]    pending;
  logic [NUM_PORTS-1:0]    grant;
  logic [PORT_IDX_W-1:0]   grant_idx;
  logic [PORT_IDX_W-1:0]   cand;
  logic                    grant_valid;

  logic [CALC1_RESP_W-1:0] alu_resp;
  logic [DATA_W-1:0]       alu_result;

  assign cmd_in[0]  = bus.req1_cmd_in;
  assign cmd_in[1]  = bus.req2_cmd_in;
  assign cmd_in[2]  = bus.req3_cmd_in;
  assign cmd_in[3]  = bus.req4_cmd_in;
  assign data_in[0] = bus.req1_data_in;
  assign data_in[1] = bus.req2_data_in;
  assign data_in[2] = bus.req3_data_in;
  assign data_in[3] = bus.req4_data_in;

  assign bus.out_resp1 = resp_q[0];
  assign bus.out_resp2 = resp_q[1];
  assign bus.out_resp3 = resp_q[2];
  assign bus.out_resp4 = resp_q[3];
  assign bus.out_data1 = data_q[0];
  assign bus.out_data2 = data_q[1];
  assign bus.out_data3 = data_q[2];
  assign bus.out_data4 = data_q[3];

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    port_state_e             state_reg;
    port_state_e             state_next;
    logic [CALC1_CMD_W-1:0]  cmd_reg;
    logic [DATA_W-1:0]       op1_reg;
    logic [DATA_W-1:0]       op2_reg;
    logic [CALC1_RESP_W-1:0] resp_reg;
    logic [DATA_W-1:0]       data_reg;

    // cmd is only looked at in IDLE, so requests arriving mid-operation are silently dropped.
    always_comb begin
      state_next = state_reg;
      case (state_reg)
        PORT_IDLE:    if (cmd_in[gi] != CMD_NONE) state_next = PORT_OP2;
        PORT_OP2:     state_next = PORT_PENDING;
        PORT_PENDING: if (grant[gi]) state_next = PORT_IDLE;
        default:      state_next = PORT_IDLE;
      endcase
    end

    always_ff @(posedge c_clk) begin
      if (reset) begin
        state_reg <= PORT_IDLE;
        cmd_reg   <= '0;
        op1_reg   <= '0;
        op2_reg   <= '0;
        resp_reg  <= '0;
        data_reg  <= '0;
      end else begin
        state_reg <= state_next;
        if (state_reg == PORT_IDLE && cmd_in[gi] != CMD_NONE) begin
          cmd_reg <= cmd_in[gi];
          op1_reg <= data_in[gi];
        end
        if (state_reg == PORT_OP2) begin
          op2_reg <= data_in[gi];
        end
        resp_reg <= grant[gi] ? alu_resp : '0;
        data_reg <= grant[gi] ? alu_result : '0;
      end
    end

    assign pending[gi] = (state_reg == PORT_PENDING);
    assign cmd_q[gi]   = cmd_reg;
    assign op1_q[gi]   = op1_reg;
    assign op2_q[gi]   = op2_reg;
    assign resp_q[gi]  = resp_reg;
    assign data_q[gi]  = data_reg;
  end

`ifndef CALC1_ARB_FIXED_PRIO_EN
  logic [PORT_IDX_W-1:0] rr_ptr_reg;

  // The port after the last winner gets first look next cycle.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      rr_ptr_reg <= '0;
    end else if (grant_valid) begin
      rr_ptr_reg <= next_port(grant_idx);
    end
  end
`endif

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
`ifdef CALC1_ARB_FIXED_PRIO_EN
      cand = PORT_IDX_W'(i);
`else
      cand = rr_ptr_reg + PORT_IDX_W'(i);
`endif
      if (!grant_valid && pending[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
    grant[grant_idx] = grant_valid;
  end

  calc1_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .cmd    (cmd_q[grant_idx]),
    .op1    (op1_q[grant_idx]),
    .op2    (op2_q[grant_idx]),
    .resp   (alu_resp),
    .result (alu_result)
  );

endmodule

// File: tb/tb_calc1_req_arbiter.sv
// Directed self-checking bench for calc1_req_arbiter.
// Each scenario task drives its stimulus and checks responses against hand-computed values.
module tb_calc1_req_arbiter;
  import calc1_pkg::*;

  logic c_clk;
  logic reset;
  int   checks;
  int   errors;

  calc1_req_arbiter_if #(.DATA_W(32)) bus ();

  calc1_req_arbiter #(
    .NUM_PORTS (4),
    .DATA_W    (32)
  ) dut (
    .c_clk (c_clk),
    .reset (reset),
    .bus   (bus)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [3:0] cmd, input logic [31:0] data);
    case (p)
      1: begin bus.req1_cmd_in = cmd; bus.req1_data_in = data; end
      2: begin bus.req2_cmd_in = cmd; bus.req2_data_in = data; end
      3: begin bus.req3_cmd_in = cmd; bus.req3_data_in = data; end
      default: begin bus.req4_cmd_in = cmd; bus.req4_data_in = data; end
    endcase
  endtask

  function automatic logic [1:0] get_resp(input int p);
    case (p)
      1: return bus.out_resp1;
      2: return bus.out_resp2;
      3: return bus.out_resp3;
      default: return bus.out_resp4;
    endcase
  endfunction

  function automatic logic [31:0] get_data(input int p);
    case (p)
      1: return bus.out_data1;
      2: return bus.out_data2;
      3: return bus.out_data3;
      default: return bus.out_data4;
    endcase
  endfunction

  task automatic do_reset();
    for (int p = 1; p <= 4; p++) set_port(p, 4'd0, 32'd0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Cycle T: cmd + op1; cycle T+1: op2. Returns at the start of T+2.
  task automatic issue(input int p, input logic [3:0] cmd, input logic [31:0] op1,
                       input logic [31:0] op2);
    set_port(p, cmd, op1);
    tick();
    set_port(p, 4'd0, op2);
    tick();
    set_port(p, 4'd0, 32'd0);
  endtask

  task automatic issue_all_add11();
    for (int p = 1; p <= 4; p++) set_port(p, 4'd1, 32'h1);
    tick();
    for (int p = 1; p <= 4; p++) set_port(p, 4'd0, 32'h1);
    tick();
    for (int p = 1; p <= 4; p++) set_port(p, 4'd0, 32'h0);
  endtask

  task automatic test_reset();
    do_reset();
    for (int p = 1; p <= 4; p++) begin
      checks++;
      if (get_resp(p) !== 2'd0) begin
        errors++;
        $display("FAIL reset_resp%0d: got %0d expected 0", p, get_resp(p));
      end
      checks++;
      if (get_data(p) !== 32'd0) begin
        errors++;
        $display("FAIL reset_data%0d: got %h expected 00000000", p, get_data(p));
      end
    end
  endtask

  task automatic test_basic_add();
    do_reset();
    issue(1, 4'd1, 32'h0000_0001, 32'h1FFF_FFFF);
    checks++;
    if (get_resp(1) !== 2'd0) begin
      errors++;
      $display("FAIL basic_early_resp1: got %0d expected 0", get_resp(1));
    end
    tick();
    checks++;
    if (get_resp(1) !== 2'd1) begin
      errors++;
      $display("FAIL basic_resp1: got %0d expected 1", get_resp(1));
    end
    checks++;
    if (get_data(1) !== 32'h2000_0000) begin
      errors++;
      $display("FAIL basic_data1: got %h expected 20000000", get_data(1));
    end
    for (int p = 2; p <= 4; p++) begin
      checks++;
      if (get_resp(p) !== 2'd0 || get_data(p) !== 32'd0) begin
        errors++;
        $display("FAIL basic_idle_port%0d: got resp %0d data %h expected 0/0", p, get_resp(p), get_data(p));
      end
    end
    tick();
    checks++;
    if (get_resp(1) !== 2'd0 || get_data(1) !== 32'd0) begin
      errors++;
      $display("FAIL basic_one_cycle: got resp %0d data %h expected 0/0", get_resp(1), get_data(1));
    end
  endtask

  task automatic test_overflow_underflow();
    do_reset();
    set_port(1, 4'd1, 32'hFFFF_FFFF);
    set_port(2, 4'd2, 32'h0000_0001);
    tick();
    set_port(1, 4'd0, 32'h0000_0001);
    set_port(2, 4'd0, 32'h0000_000F);
    tick();
    set_port(1, 4'd0, 32'h0);
    set_port(2, 4'd0, 32'h0);
    tick();
    checks++;
    if (get_resp(1) !== 2'd2 || get_data(1) !== 32'd0 || get_resp(2) !== 2'd0) begin
      errors++;
      $display("FAIL overflow_p1: got resp1 %0d data1 %h resp2 %0d expected 2/00000000/0",
               get_resp(1), get_data(1), get_resp(2));
    end
    tick();
    checks++;
    if (get_resp(2) !== 2'd2 || get_data(2) !== 32'd0 || get_resp(1) !== 2'd0) begin
      errors++;
      $display("FAIL underflow_p2: got resp2 %0d data2 %h resp1 %0d expected 2/00000000/0",
               get_resp(2), get_data(2), get_resp(1));
    end
    issue(2, 4'd2, 32'h0000_0007, 32'h0000_0007);
    tick();
    checks++;
    if (get_resp(2) !== 2'd1 || get_data(2) !== 32'd0) begin
      errors++;
      $display("FAIL sub_equal_p2: got resp %0d data %h expected 1/00000000", get_resp(2), get_data(2));
    end
    issue(2, 4'd2, 32'h0000_0010, 32'h0000_0003);
    tick();
    checks++;
    if (get_resp(2) !== 2'd1 || get_data(2) !== 32'h0000_000D) begin
      errors++;
      $display("FAIL sub_normal_p2: got resp %0d data %h expected 1/0000000d", get_resp(2), get_data(2));
    end
  endtask

  task automatic check_round(input string name);
    logic [1:0]  exp_r;
    logic [31:0] exp_d;
    for (int c = 1; c <= 4; c++) begin
      tick();
      for (int p = 1; p <= 4; p++) begin
        exp_r = (p == c) ? 2'd1 : 2'd0;
        exp_d = (p == c) ? 32'h2 : 32'h0;
        checks++;
        if (get_resp(p) !== exp_r || get_data(p) !== exp_d) begin
          errors++;
          $display("FAIL %s slot%0d port%0d: got resp %0d data %h expected %0d/%h",
                   name, c, p, get_resp(p), get_data(p), exp_r, exp_d);
        end
      end
    end
  endtask

  task automatic test_all_ports_and_back_to_back();
    do_reset();
    issue_all_add11();
    check_round("all_ports");
    // Re-issue in the cycle the last response is visible.
    issue_all_add11();
    check_round("back_to_back");
  endtask

  task automatic test_invalid_and_shift();
    do_reset();
    issue(3, 4'd3, 32'h1234_5678, 32'h1);
    tick();
    checks++;
    if (get_resp(3) !== 2'd2 || get_data(3) !== 32'd0) begin
      errors++;
      $display("FAIL invalid_cmd3: got resp %0d data %h expected 2/00000000", get_resp(3), get_data(3));
    end
    issue(3, 4'd4, 32'h0000_0001, 32'h0000_0002);
    tick();
    checks++;
    if (get_resp(3) !== 2'd2 || get_data(3) !== 32'd0) begin
      errors++;
      $display("FAIL invalid_cmd4: got resp %0d data %h expected 2/00000000", get_resp(3), get_data(3));
    end
    issue(3, 4'd5, 32'h0000_0001, 32'h0000_001F);
    tick();
    checks++;
    if (get_resp(3) !== 2'd1 || get_data(3) !== 32'h8000_0000) begin
      errors++;
      $display("FAIL shl_p3: got resp %0d data %h expected 1/80000000", get_resp(3), get_data(3));
    end
    issue(3, 4'd6, 32'h8000_0000, 32'hFFFF_FFE4);
    tick();
    checks++;
    if (get_resp(3) !== 2'd1 || get_data(3) !== 32'h0800_0000) begin
      errors++;
      $display("FAIL shr_p3: got resp %0d data %h expected 1/08000000", get_resp(3), get_data(3));
    end
  endtask

  task automatic test_ignore_busy_cmd();
    do_reset();
    set_port(1, 4'd1, 32'h3);
    tick();
    set_port(1, 4'd2, 32'h4);
    tick();
    set_port(1, 4'd1, 32'h9);
    tick();
    set_port(1, 4'd0, 32'h0);
    checks++;
    if (get_resp(1) !== 2'd1 || get_data(1) !== 32'h7) begin
      errors++;
      $display("FAIL ignore_first: got resp %0d data %h expected 1/00000007", get_resp(1), get_data(1));
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (get_resp(1) !== 2'd0) begin
        errors++;
        $display("FAIL ignore_extra cycle%0d: got resp %0d expected 0", c, get_resp(1));
      end
    end
  endtask

  task automatic test_reset_mid_flight();
    do_reset();
    set_port(4, 4'd1, 32'h1);
    tick();
    set_port(4, 4'd0, 32'h2);
    set_port(1, 4'd1, 32'h7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_port(4, 4'd0, 32'h0);
    set_port(1, 4'd0, 32'h0);
    for (int c = 0; c < 6; c++) begin
      for (int p = 1; p <= 4; p++) begin
        checks++;
        if (get_resp(p) !== 2'd0 || get_data(p) !== 32'd0) begin
          errors++;
          $display("FAIL reset_mid cycle%0d port%0d: got resp %0d data %h expected 0/0",
                   c, p, get_resp(p), get_data(p));
        end
      end
      tick();
    end
    issue(4, 4'd1, 32'h5, 32'h6);
    tick();
    checks++;
    if (get_resp(4) !== 2'd1 || get_data(4) !== 32'hB) begin
      errors++;
      $display("FAIL reset_mid_recover: got resp %0d data %h expected 1/0000000b", get_resp(4), get_data(4));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    for (int p = 1; p <= 4; p++) set_port(p, 4'd0, 32'd0);
    tick();
    test_reset();
    test_basic_add();
    test_overflow_underflow();
    test_all_ports_and_back_to_back();
    test_invalid_and_shift();
    test_ignore_busy_cmd();
    test_reset_mid_flight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
